// File: rtl/instr_prefetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue_pkg
// Shared types and constants for the instruction prefetch queue.
//   fetch_entry_t : one buffered fetch result, the word plus the PC it came from
//   INSTR_NOP     : harmless word presented on out_instr when nothing is valid
//   PC_STEP       : sequential fetch increment, one 32-bit word
//   align_word()  : clears address bits [1:0]
// ----------------------------------------------------------------------------
package instr_prefetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Masking rather than slicing keeps every input bit formally used.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
// Synchronous FIFO with flush, used both for the fetch-entry queue and for the
// PC tag FIFO that remembers the address of every live outstanding request.
// The head entry is read straight from the storage registers so the consumer
// sees it in the same cycle it becomes valid.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_push/i_data write one entry (ignored when full and not popping)
//   i_pop         remove head entry (ignored when empty)
//   i_flush       discard all entries next cycle; overrides push and pop
//   o_data        head entry
//   o_count       number of stored entries, 0..DEPTH
//   o_full/o_empty occupancy flags
// ----------------------------------------------------------------------------
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_next;

  assign o_full  = (r_count == DEPTH_W);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only allowed when the head leaves the same cycle.
  assign w_push = i_push && (!o_full || i_pop);
  assign w_pop  = i_pop && !o_empty;

  assign w_count_next = r_count
                      + {{AW{1'b0}}, w_push}
                      - {{AW{1'b0}}, w_pop};

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue
// Instruction-fetch front end between instruction memory and decode. Issues
// sequential word fetches over a req/gnt + rvalid handshake, buffers returned
// words with their PC in a DEPTH-entry queue and presents them on a
// valid/ready port. A redirect flushes the queue, discards responses that are
// still in flight and restarts fetch at the target.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   imem_req/imem_addr          fetch request and word-aligned address
//   imem_gnt                    memory accepts the request (req && gnt = issue)
//   imem_rvalid/imem_rdata      in-order response, at least one cycle after issue
//   redirect_valid/redirect_pc  flush and restart (target bits [1:0] ignored)
//   out_valid/out_ready         decode handshake (valid && ready = pop)
//   out_instr/out_pc            head instruction and its PC
//
// Build option IFQ_BYPASS_EN: when the queue is empty and nothing is being
// discarded, a live response is presented to decode in the same cycle it
// arrives and, if accepted, never enters the queue. Without the macro every
// output comes from queue registers and there is no memory-to-decode
// combinational path.
// ----------------------------------------------------------------------------
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam int          EW      = $bits(fetch_entry_t);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  // Fetch address and request accounting.
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight;   // issued, response not yet seen
  logic [CW-1:0] r_drop;       // of those, responses belonging to a flushed stream

  logic [31:0]   w_fetch_pc_next;
  logic [CW-1:0] w_inflight_next;
  logic [CW-1:0] w_drop_next;

  // Queue and tag FIFO interface.
  fetch_entry_t  w_rsp_entry;
  fetch_entry_t  w_q_head;
  fetch_entry_t  w_out_entry;
  logic [CW-1:0] w_occ;
  logic          w_q_full;
  logic          w_q_empty;
  logic          w_q_push;
  logic          w_q_pop;
  logic [31:0]   w_tag_head;
  logic [CW-1:0] w_tag_count;
  logic          w_tag_full;
  logic          w_tag_empty;

  // Per-cycle events.
  logic [CW:0]   w_credit_used;
  logic          w_issue;
  logic          w_rsp;
  logic          w_rsp_live;
  logic          w_bypass;
  logic          w_pop_ok;

  // --------------------------------------------------------------------------
  // Request credit. Every live outstanding request owns a tag FIFO slot, so
  // occ + tag_count counts queue slots that are taken or promised. Keeping
  // that below DEPTH guarantees every live response finds a free queue slot.
  // --------------------------------------------------------------------------
  assign w_credit_used = {1'b0, w_occ} + {1'b0, w_tag_count};

  assign imem_req  = rst_n
                   && !redirect_valid
                   && (w_credit_used < DEPTH_W)
                   && ({1'b0, r_inflight} < DEPTH_W)
                   && !w_tag_full
                   && !w_q_full;
  assign imem_addr = r_fetch_pc;

  assign w_issue = imem_req && imem_gnt;

  // A response with nothing outstanding is a stray and is ignored entirely.
  assign w_rsp = imem_rvalid && (r_inflight != '0);

  // Live: belongs to the current stream and is not killed by a redirect now.
  assign w_rsp_live = w_rsp && (r_drop == '0) && !redirect_valid && !w_tag_empty;

  assign w_rsp_entry.pc    = w_tag_head;
  assign w_rsp_entry.instr = imem_rdata;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_rsp_live && w_q_empty;
`else
  assign w_bypass = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Decode port. A pop in a redirect cycle is ignored: the head it would
  // remove is being flushed anyway.
  // --------------------------------------------------------------------------
  assign w_out_entry = w_bypass ? w_rsp_entry : w_q_head;
  assign out_valid   = !w_q_empty || w_bypass;
  assign out_pc      = w_out_entry.pc;
  assign out_instr   = out_valid ? w_out_entry.instr : INSTR_NOP;

  assign w_pop_ok = out_valid && out_ready && !redirect_valid;

  // A bypassed word taken by decode this cycle never needs to be stored.
  assign w_q_push = w_rsp_live && !(w_bypass && out_ready);
  assign w_q_pop  = w_pop_ok && !w_bypass;

  // --------------------------------------------------------------------------
  // Next-state for fetch PC and counters. The redirect branch issues nothing
  // (imem_req is held low), so all outstanding requests minus a response
  // arriving right now become responses to discard.
  // --------------------------------------------------------------------------
  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    w_inflight_next = r_inflight
                    + {{(CW-1){1'b0}}, w_issue}
                    - {{(CW-1){1'b0}}, w_rsp};
    w_drop_next     = r_drop;

    if (redirect_valid) begin
      w_fetch_pc_next = align_word(redirect_pc);
      w_drop_next     = w_inflight_next;
    end else begin
      if (w_issue) begin
        w_fetch_pc_next = r_fetch_pc + PC_STEP;   // wraps 32'hFFFF_FFFC -> 0
      end
      if (w_rsp && (r_drop != '0)) begin
        w_drop_next = r_drop - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_inflight <= w_inflight_next;
      r_drop     <= w_drop_next;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: fetched entries, and the PC of each live outstanding request.
  // Tags of discarded requests vanish with the redirect flush, which is why
  // a tag is only popped for a live response.
  // --------------------------------------------------------------------------
  ifq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_q_push),
    .i_data  (w_rsp_entry),
    .i_pop   (w_q_pop),
    .i_flush (redirect_valid),
    .o_data  (w_q_head),
    .o_count (w_occ),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  ifq_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_issue),
    .i_data  (r_fetch_pc),
    .i_pop   (w_rsp_live),
    .i_flush (redirect_valid),
    .o_data  (w_tag_head),
    .o_count (w_tag_count),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

endmodule
